// File: rtl/snake_seg_scan.sv
// Snake field display reader: copies the 8x8 field RAM into a shadow buffer, swaps it
// into a display buffer, and scans that buffer onto eight 7-segment digits.
// Optional anti-ghosting blanking is enabled by defining SNAKE_SCAN_BLANK_EN.
module snake_seg_scan #(
    parameter int unsigned DIGIT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_req,
    output logic       rd_en,
    output logic [2:0] rd_row,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       segA,
    output logic       segB,
    output logic       segC,
    output logic       segD,
    output logic       segE,
    output logic       segF,
    output logic       segG,
    output logic       segDP,
    output logic [7:0] dig_sel,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LAST = 2'd2,
        S_SWAP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_pending;
    logic        w_pending_next;
    logic [2:0]  r_row;
    logic [2:0]  w_row_next;
    logic [7:0]  r_shadow [8];
    logic [7:0]  r_disp   [8];
    logic [15:0] r_presc;
    logic [2:0]  r_digit;
    logic [7:0]  r_dig_sel;
    logic [7:0]  r_seg;
    logic        w_presc_wrap;
    logic        w_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_row     <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_pending_next;
            r_row     <= w_row_next;
        end
    end

    // Requests arriving outside IDLE collapse into one pending copy.
    always_comb begin
        w_next         = r_state;
        w_row_next     = r_row;
        w_pending_next = r_pending | update_req;
        case (r_state)
            S_IDLE: begin
                if (update_req || r_pending) begin
                    w_next         = S_READ;
                    w_row_next     = 3'd0;
                    w_pending_next = 1'b0;
                end
            end
            S_READ: begin
                if (r_row == 3'd7) w_next = S_LAST;
                else               w_row_next = r_row + 3'd1;
            end
            S_LAST:  w_next = S_SWAP;
            S_SWAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read data lags the strobe by one cycle, so each capture targets the previous row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 8'hFF;
                r_disp[i]   <= 8'hFF;
            end
        end else begin
            if (r_state == S_READ && r_row != 3'd0) r_shadow[r_row - 3'd1] <= rd_data;
            if (r_state == S_LAST) r_shadow[7] <= rd_data;
            if (r_state == S_SWAP) begin
                for (int i = 0; i < 8; i++) r_disp[i] <= r_shadow[i];
            end
        end
    end

    assign w_presc_wrap = (r_presc == 16'(DIGIT_CYCLES - 1));

`ifdef SNAKE_SCAN_BLANK_EN
    assign w_blank = (r_presc < 16'd2);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= 16'd0;
            r_digit   <= 3'd0;
            r_dig_sel <= 8'hFF;
            r_seg     <= 8'h00;
        end else begin
            r_presc <= w_presc_wrap ? 16'd0 : r_presc + 16'd1;
            if (w_presc_wrap) r_digit <= r_digit + 3'd1;
            r_dig_sel <= w_blank ? 8'hFF : ~(8'd1 << r_digit);
            r_seg     <= w_blank ? 8'h00 : ~r_disp[r_digit];
        end
    end

    assign rd_en     = (r_state == S_READ);
    assign rd_row    = r_row;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_SWAP);
    assign dig_sel   = r_dig_sel;
    assign dbg_state = r_state;
    assign {segDP, segG, segF, segE, segD, segC, segB, segA} = r_seg;

endmodule

// File: tb/tb_snake_seg_scan.sv
// Directed bench for snake_seg_scan: scan sequence, copy timing, pending requests,
// mid-copy RAM changes and asynchronous reset during a copy.
module tb_snake_seg_scan;

`ifdef SNAKE_SCAN_BLANK_EN
    localparam int DC = 8;
`else
    localparam int DC = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       update_req;
    logic       rd_en;
    logic [2:0] rd_row;
    logic [7:0] rd_data = 8'hFF;
    logic       busy;
    logic       done;
    logic       segA, segB, segC, segD, segE, segF, segG, segDP;
    logic [7:0] dig_sel;
    logic [1:0] dbg_state;
    logic [7:0] mem [8];
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

    snake_seg_scan #(.DIGIT_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .update_req(update_req),
        .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data),
        .busy(busy), .done(done),
        .segA(segA), .segB(segB), .segC(segC), .segD(segD),
        .segE(segE), .segF(segF), .segG(segG), .segDP(segDP),
        .dig_sel(dig_sel), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign seg = {segDP, segG, segF, segE, segD, segC, segB, segA};

    // Synchronous-read field RAM model.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_row];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dig(input logic [7:0] d, input string tag);
        int n = 0;
        while (dig_sel !== d && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int ndone;
        int last_done;
        int bad;
        logic [7:0] exp_sel;

        rst_n      = 1'b0;
        update_req = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
        repeat (2) step();
        chk("rst_dig_sel", 32'(dig_sel), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_row", 32'(rd_row), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);

        // Idle scan sequence after reset release.
        rst_n = 1'b1;
        for (int n = 1; n <= 9 * DC; n++) begin
            step();
            exp_sel = ~(8'd1 << (((n - 1) / DC) % 8));
`ifdef SNAKE_SCAN_BLANK_EN
            if (((n - 1) % DC) < 2) exp_sel = 8'hFF;
`endif
            chk("scan_dig_sel", 32'(dig_sel), 32'(exp_sel));
            chk("scan_seg", 32'(seg), 32'h00);
            chk("scan_busy", 32'(busy), 32'd0);
        end

        // Single copy with row 2 = FE: timing of rd_en/rd_row/busy/done.
        mem[2] = 8'hFE;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            chk("copy_rd_en", 32'(rd_en), 32'(c <= 8));
            chk("copy_rd_row", 32'(rd_row), (c <= 8) ? 32'(c - 1) : 32'd7);
            chk("copy_busy", 32'(busy), 32'(c <= 10));
            chk("copy_done", 32'(done), 32'(c == 10));
            step();
        end
        wait_dig(8'hFB, "wait_dig2");
        chk("row2_seg", 32'(seg), 32'h01);
        wait_dig(8'hFD, "wait_dig1");
        chk("row1_seg", 32'(seg), 32'h00);
        wait_dig(8'hFE, "wait_dig0");
        chk("row0_seg", 32'(seg), 32'h00);

        // Requests during READ collapse into one extra copy; row 0 changed after its read.
        ndone = 0;
        last_done = 0;
        update_req = 1'b1;
        step();
        for (int c = 1; c <= 25; c++) begin
            update_req = (c == 3 || c == 5);
            if (c == 3) mem[0] = 8'h7F;
            if (done) begin
                ndone++;
                last_done = c;
            end
            if (c == 11) chk("pend_gap_rd_en", 32'(rd_en), 32'd0);
            if (c == 12) chk("pend_restart_rd_en", 32'(rd_en), 32'd1);
            if (c == 12) chk("pend_restart_row", 32'(rd_row), 32'd0);
            step();
        end
        update_req = 1'b0;
        chk("pend_done_count", 32'(ndone), 32'd2);
        chk("pend_second_done", 32'(last_done), 32'd21);
        chk("pend_busy_after", 32'(busy), 32'd0);
        wait_dig(8'hFE, "wait_pend0");
        chk("pend_row0_seg", 32'(seg), 32'h80);
        wait_dig(8'hFB, "wait_pend2");
        chk("pend_row2_seg", 32'(seg), 32'h01);

        // RAM row 0 rewritten after it was read: display keeps the old row until recopied.
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 3) mem[0] = 8'hBF;
            if (c == 10) chk("mid_done", 32'(done), 32'd1);
            step();
        end
        wait_dig(8'hFE, "wait_mid_old");
        chk("mid_old_row0", 32'(seg), 32'h80);
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        repeat (11) step();
        wait_dig(8'hFE, "wait_mid_new");
        chk("mid_new_row0", 32'(seg), 32'h40);

        // Asynchronous reset during READ of row 4.
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        repeat (4) step();
        chk("abort_pre_row", 32'(rd_row), 32'd4);
        chk("abort_pre_rd_en", 32'(rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_rd_row", 32'(rd_row), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dig_sel", 32'(dig_sel), 32'hFF);
        chk("abort_seg", 32'(seg), 32'h00);
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 9 * DC; c++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0 || seg !== 8'h00) bad++;
        end
        chk("abort_stays_blank", 32'(bad), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snake_seg_scan.md
# snake_seg_scan

Display-side reader for the snake game field. On request from the game logic it copies the 8x8 field out of the field RAM through a synchronous read port into a shadow buffer, then swaps that buffer atomically into a display buffer. It continuously time-multiplexes the display buffer onto eight 7-segment digits: row k drives digit k, and column i drives segment i (A..G, DP). It sits between the game step logic, which writes the field, and the board's segA..segDP pins.

## Interface
- `DIGIT_CYCLES`, default 1024: clock cycles each digit stays selected. Legal range is 2..65535.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `update_req` in 1: single-cycle pulse meaning the field has changed and should be re-read.
- `rd_en` out 1: field RAM read strobe.
- `rd_row` out 3: field RAM row address.
- `rd_data` in 8: field row data, valid the cycle after `rd_en`. Bit i is column i.
- `busy` out 1: high while a copy is in progress.
- `done` out 1: one-cycle pulse when the display buffer has been swapped.
- `segA`, `segB`, `segC`, `segD`, `segE`, `segF`, `segG`, `segDP` out 1 each: active-high segment drives.
- `dig_sel` out 8: active-low one-hot digit enables.

## Operation
- Cell encoding: a field bit of 0 marks a snake cell. The corresponding segment is lit (output 1) when the displayed bit is 0.
- Fetch FSM states:
  - IDLE: when `update_req` is seen or `pending` is set, clear `pending`, set row counter to 0, go to READ.
  - READ: assert `rd_en` with `rd_row` = row counter for 8 consecutive cycles (rows 0..7). Capture `rd_data` into shadow[row-1] one cycle after each read. After issuing row 7, go to LAST.
  - LAST: capture shadow[7], go to SWAP.
  - SWAP: copy shadow into the display buffer, pulse `done`, go to IDLE.
- `update_req` while not in IDLE sets `pending`. Any number of requests during one copy collapse into exactly one further copy, which starts from IDLE on the next cycle.
- `update_req` in IDLE is accepted the same cycle. A request arriving in the SWAP cycle sets `pending`.
- Scan logic:
  - A prescaler counts 0..DIGIT_CYCLES-1. On wrap, the digit counter increments, and 7 wraps to 0.
  - `dig_sel` = ~(1 << digit).
  - {segDP,segG,...,segA} = ~disp[digit]. Both are registered and change on the same edge.
  - Scanning never stalls. It always reads the display buffer, so the game never sees a partially updated frame.
- Reset, asynchronous and mid-operation:
  - FSM goes to IDLE, `pending`=0, `busy`=0, `done`=0, `rd_en`=0, `rd_row`=0.
  - Shadow and display buffers are all 1s (empty).
  - Prescaler=0, digit=0, `dig_sel`=8'hFF, all seg outputs=0.
  - An aborted copy is discarded and not resumed.

## Timing
- `update_req` high in IDLE at cycle 0 gives:
  - `rd_en`=1 in cycles 1..8 with `rd_row`=0..7.
  - `busy`=1 in cycles 1..10.
  - SWAP in cycle 10 with `done`=1.
  - New data visible on segments from the cycle-11 output register update at the latest.
- Copy latency is fixed: 10 cycles from request to `done`. Back-to-back copies (with `pending` set) restart READ 2 cycles after `done`: IDLE, then READ.
- `busy` rises in the cycle after `update_req` and falls in the cycle after `done`.
- First scan output after reset release: digit 0 is selected after the first edge, `dig_sel`=8'hFE. Each digit then holds for exactly DIGIT_CYCLES cycles, for a full frame period of 8*DIGIT_CYCLES.
- `rd_en` is never asserted outside READ, and `rd_row` holds its last value when idle.

## Configuration
- Macro: `SNAKE_SCAN_BLANK_EN`.
  - Defined: during prescaler counts 0 and 1 of every digit slot, `dig_sel`=8'hFF and segments are 0 (anti-ghosting blanking). The digit is driven for the remaining DIGIT_CYCLES-2 cycles.
  - Undefined: no blanking; the digit is driven for the full slot.
- Copy behaviour is identical in both builds.

## Test plan
- Reset then idle with DIGIT_CYCLES=4 → `dig_sel` cycles FE,FD,FB,...,7F, 4 cycles each; segments all 0; `busy`=0.
- Field row 2 = 8'b1111_1110, all other rows 8'hFF, then `update_req` pulse → `rd_en` for 8 cycles, `done` at request+10. While `dig_sel`=FB, segA=1 and the other segments are 0; all other digits are blank.
- `update_req` in READ cycles 3 and 5 → exactly two copies and two `done` pulses. The second copy begins READ 2 cycles after the first `done`.
- Field RAM changed mid-copy, row 0 after it was read → the display shows the old row 0 until the second (pending) copy completes.
- `rst_n` low during READ row 4 → outputs take their reset values immediately; no `done`; the display stays blank.
- `SNAKE_SCAN_BLANK_EN` defined with DIGIT_CYCLES=8 → each slot shows `dig_sel`=FF for 2 cycles, then the active digit for 6 cycles.
